fetch_buffer: RTL
=================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter: DEPTH, default 2, number of instruction buffer entries; the block SHALL support only powers of two from 2 to 8.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: pc_q  input  32  current word-addressed fetch PC, taken from the PC register.
REQ-005 Port: pc_en  output  1  advance/load enable for the PC register.
REQ-006 Port: flush  input  1  redirect: branch, jump or JR taken this cycle.
REQ-007 Port: imem_req  output  1  instruction-memory request valid.
REQ-008 Port: imem_addr  output  12  instruction-memory word address.
REQ-009 Port: imem_gnt  input  1  request accepted this cycle.
REQ-010 Port: imem_rvalid  input  1  read data valid.
REQ-011 Port: imem_rdata  input  32  instruction word.
REQ-012 Port: dec_valid  output  1  head entry valid toward decode.
REQ-013 Port: dec_ready  input  1  decode accepts head entry.
REQ-014 Port: dec_insn, dec_pc, dec_pc_plus  output  32 each  head instruction, its PC, and its PC+1.

Function
REQ-015 The block SHALL implement the fetch FSM states IDLE (nothing outstanding), WAIT (one request outstanding) and DROP (one outstanding response to be discarded).
REQ-016 The block SHALL keep at most one request outstanding at a time.
REQ-017 imem_req SHALL be asserted only when: state is IDLE, flush is 0, and occupancy < DEPTH.
REQ-018 imem_addr SHALL equal pc_q[11:0], a combinational path that stays stable while imem_req is high.
REQ-019 A request SHALL be accepted when imem_req and imem_gnt are both high; acceptance SHALL latch pc_q as the tag and move the FSM from IDLE to WAIT.
REQ-020 pc_en SHALL equal (request accepted) OR flush, so the PC loads pc_calc's next value or the redirect target in the same cycle.
REQ-021 In WAIT with imem_rvalid=1 and flush=0, the block SHALL push {imem_rdata, tag} into the buffer and return to IDLE.
REQ-022 Latency: a grant at cycle N with rvalid at cycle N+k (k>=1) SHALL give dec_valid=1 at cycle N+k+1.
REQ-023 In WAIT with flush=1 and no rvalid, the FSM SHALL go to DROP; in WAIT with flush=1 and rvalid=1, the response SHALL be discarded and the FSM SHALL go to IDLE.
REQ-024 In DROP, rvalid SHALL be discarded and the FSM SHALL return to IDLE; a further flush in DROP SHALL leave it in DROP.
REQ-025 imem_rvalid in IDLE SHALL be ignored.
REQ-026 The buffer SHALL be a circular FIFO with DEPTH entries, log2(DEPTH)-bit read and write pointers that wrap modulo DEPTH, and a separate occupancy counter from 0 to DEPTH.
REQ-027 Buffer overflow SHALL be impossible by construction (REQ-017); a simultaneous push and pop SHALL leave occupancy unchanged.
REQ-028 dec_valid SHALL equal (occupancy != 0) AND NOT flush; a pop SHALL occur only on dec_valid AND dec_ready.
REQ-029 dec_insn and dec_pc SHALL show the head entry; dec_pc_plus SHALL equal dec_pc+1 modulo 2^32, with 0xFFFFFFFF giving 0.
REQ-030 flush SHALL clear occupancy and both pointers on the next edge and block any pop or push in the flush cycle.
REQ-031 flush SHALL override every simultaneous event: push, pop and grant.

Reset
REQ-032 While rst=1, the block SHALL hold state IDLE, occupancy 0, pointers 0 and tag 0.
REQ-033 While rst=1, imem_req, pc_en and dec_valid SHALL be 0, and dec_insn, dec_pc and dec_pc_plus SHALL read 0.
REQ-034 Reset asserted mid-request SHALL abandon the outstanding request; a later stray rvalid SHALL be ignored per REQ-025.

Verification
REQ-035 Basic fetch: pc_q=0x10, gnt=1 at cycle 1, rvalid=1 with rdata=0xA5A50001 at cycle 3 -> pc_en=1 at cycle 1 only; dec_valid=1 from cycle 4 with dec_insn=0xA5A50001, dec_pc=0x10, dec_pc_plus=0x11.
REQ-036 Full buffer (DEPTH=2): dec_ready=0, two fetches completed -> imem_req stays 0; one pop -> imem_req=1 again next cycle.
REQ-037 Flush with response in flight: grant, then flush one cycle later, then rvalid two cycles later -> the FSM passes WAIT, DROP, IDLE; the response is never visible and dec_valid stays 0.
REQ-038 Flush coincident with rvalid and with 1 buffered entry -> occupancy 0 next cycle, dec_valid=0, pc_en=1 in the flush cycle.
REQ-039 Wrap and limits: 5 back-to-back fetch/pop pairs with DEPTH=2 -> PCs delivered in order; the entry with dec_pc=0xFFFFFFFF gives dec_pc_plus=0.
REQ-040 Reset in WAIT, then a stray rvalid -> no push; all outputs 0 while rst=1; the first request after reset uses imem_addr=pc_q[11:0].

Source files
------------

// File: rtl/fetch_buffer.sv
// Instruction fetch front end: one-outstanding-request memory fetch FSM feeding
// a small circular buffer of {instruction, pc} entries toward decode.
//
// state | meaning
// IDLE  | nothing outstanding, may issue a request
// WAIT  | one request outstanding, response will be buffered
// DROP  | one outstanding response to be discarded after a redirect
module fetch_buffer #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_q,
    output logic        pc_en,
    input  logic        flush,
    output logic        imem_req,
    output logic [11:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_insn,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_pc_plus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t          state, state_nxt;
    logic [31:0]     tag;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   occ;
    logic [31:0]     mem_insn [DEPTH];
    logic [31:0]     mem_pc   [DEPTH];
    logic            accept, push, pop;

    assign imem_addr = pc_q[11:0];

    always_comb begin
        imem_req  = !rst && (state == IDLE) && !flush && (occ < CW'(DEPTH));
        accept    = imem_req && imem_gnt;
        pc_en     = !rst && (accept || flush);
        dec_valid = !rst && (occ != '0) && !flush;
        pop       = dec_valid && dec_ready;
        push      = !rst && (state == WAIT) && imem_rvalid && !flush;
    end

    // A response arriving in WAIT or DROP always ends the outstanding request,
    // whether it is kept or thrown away.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = WAIT;
            WAIT: begin
                if (imem_rvalid)  state_nxt = IDLE;
                else if (flush)   state_nxt = DROP;
            end
            DROP:    if (imem_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            tag    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) tag <= pc_q;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                occ    <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                if (push && !pop)      occ <= occ + CW'(1);
                else if (pop && !push) occ <= occ - CW'(1);
            end
        end
    end

    // Storage needs no reset: the head is only exposed once occupancy is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_insn[wr_ptr] <= imem_rdata;
            mem_pc[wr_ptr]   <= tag;
        end
    end

    always_comb begin
        dec_insn    = rst ? 32'h0 : mem_insn[rd_ptr];
        dec_pc      = rst ? 32'h0 : mem_pc[rd_ptr];
        dec_pc_plus = rst ? 32'h0 : mem_pc[rd_ptr] + 32'h1;
    end

endmodule
